// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: shared types and constants for the SPI slave with RX FIFO.
// Status flags are built when SPI_SLAVE_FIFO_STATUS_EN is defined.
package spi_slave_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/spi_rx_fifo.sv
// spi_rx_fifo: power-of-two RX word FIFO; a pop on a full FIFO frees room
// for a push in the same cycle, a pop on an empty FIFO is ignored.
module spi_rx_fifo
  import spi_slave_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign empty   = count == '0;
  assign full    = count == DEPTH_C;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/spi_slave_fifo.sv
// spi_slave_fifo: oversampled SPI slave (any CPOL/CPHA) with an RX FIFO.
// SPI_SLAVE_FIFO_STATUS_EN adds sticky overrun/underrun flags with clear.
module spi_slave_fifo
  import spi_slave_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter bit CPOL       = 1'b0,
  parameter bit CPHA       = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk_in,
  input  logic              mosi_in,
  input  logic              ss_n_in,
  output logic              miso_out,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready
`ifdef SPI_SLAVE_FIFO_STATUS_EN
  ,
  output logic              overrun_flag,
  output logic              underrun_flag,
  input  logic              flag_clr
`endif
);

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] ss_sync;
  logic                   sclk_q;
  logic                   ss_q;
  logic                   sclk_s;
  logic                   mosi_s;
  logic                   ss_s;
  logic                   lead;
  logic                   trail;
  logic                   sample;
  logic                   launch;
  logic                   ss_fall;
  logic                   ss_rise;

  state_t                 state;
  state_t                 state_d;
  logic [CW-1:0]          bit_cnt;
  logic [DATA_W-2:0]      rx_sh;
  logic [DATA_W-1:0]      tx_sh;
  logic [DATA_W-1:0]      word_q;
  logic                   push_q;
  logic                   active;
  logic                   wrap;
  logic                   load;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   drop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync <= {SYNC_STAGES{CPOL}};
      mosi_sync <= '0;
      ss_sync   <= '1;
      sclk_q    <= CPOL;
      ss_q      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_in};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n_in};
      sclk_q    <= sclk_s;
      ss_q      <= ss_s;
    end
  end

  assign sclk_s  = sclk_sync[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync[SYNC_STAGES-1];
  assign ss_s    = ss_sync[SYNC_STAGES-1];
  assign lead    = (sclk_s != sclk_q) && (sclk_s != CPOL);
  assign trail   = (sclk_s != sclk_q) && (sclk_s == CPOL);
  assign sample  = CPHA ? trail : lead;
  assign launch  = CPHA ? lead : trail;
  assign ss_fall = ss_q && !ss_s;
  assign ss_rise = !ss_q && ss_s;

  always_comb begin
    state_d = state;
    if (ss_rise) state_d = IDLE;
    else if (state == IDLE && ss_fall) state_d = SHIFT;
  end

  assign active   = state == SHIFT && !ss_rise;
  assign wrap     = active && sample && bit_cnt == LAST;
  assign load     = (state == IDLE && ss_fall) || wrap;
  assign tx_ready = load && tx_valid;
  assign miso_out = state == SHIFT && tx_sh[DATA_W-1];

  // The launch edge right after a load keeps the fresh MSB on the line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      rx_sh   <= '0;
      tx_sh   <= '0;
      word_q  <= '0;
      push_q  <= 1'b0;
    end else begin
      state  <= state_d;
      push_q <= wrap;
      if (wrap) word_q <= {rx_sh, mosi_s};
      if (!active) begin
        bit_cnt <= '0;
        rx_sh   <= '0;
      end else if (sample) begin
        bit_cnt <= wrap ? '0 : bit_cnt + 1'b1;
        rx_sh   <= {rx_sh[DATA_W-3:0], mosi_s};
      end
      if (load) tx_sh <= tx_valid ? tx_data : '0;
      else if (active && launch && bit_cnt != '0)
        tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
    end
  end

  assign drop     = fifo_full && !rx_ready;
  assign rx_valid = !fifo_empty;

  spi_rx_fifo #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push_q && !drop),
    .push_data(word_q),
    .pop      (rx_ready),
    .head     (rx_data),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

`ifdef SPI_SLAVE_FIFO_STATUS_EN
  logic overrun_set;
  logic underrun_set;

  assign overrun_set  = push_q && drop;
  assign underrun_set = load && !tx_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_flag  <= 1'b0;
      underrun_flag <= 1'b0;
    end else begin
      if (overrun_set) overrun_flag <= 1'b1;
      else if (flag_clr) overrun_flag <= 1'b0;
      if (underrun_set) underrun_flag <= 1'b1;
      else if (flag_clr) underrun_flag <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_spi_slave_fifo.sv
// tb_spi_slave_fifo: directed bench driving three slaves (mode 0, mode 3,
// and 12-bit mode 1) from one bit-banged SPI master.
module tb_spi_slave_fifo;

  localparam int H = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        sclk;
  logic        mosi;
  logic        ss_n0, ss_n3, ss_n1;
  logic        miso0, miso3, miso1;
  logic [7:0]  rx_data0, rx_data3;
  logic [11:0] rx_data1;
  logic        rx_valid0, rx_valid3, rx_valid1;
  logic        rx_ready0, rx_ready3, rx_ready1;
  logic [7:0]  tx_data0, tx_data3;
  logic [11:0] tx_data1;
  logic        tx_valid0, tx_valid3, tx_valid1;
  logic        tx_ready0, tx_ready3, tx_ready1;
`ifdef SPI_SLAVE_FIFO_STATUS_EN
  logic        ovr0, unr0, ovr3, unr3, ovr1, unr1;
  logic        flag_clr;
`endif

  int          n_checks = 0;
  int          n_fail = 0;
  int          txr_cnt0 = 0;
  int          pop_cnt1 = 0;
  logic [11:0] last_pop1 = '0;
  logic [31:0] mi;

  spi_slave_fifo u_dut0 (
    .clk(clk), .reset(reset),
    .sclk_in(sclk), .mosi_in(mosi), .ss_n_in(ss_n0),
    .miso_out(miso0),
    .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready0),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0)
`ifdef SPI_SLAVE_FIFO_STATUS_EN
    , .overrun_flag(ovr0), .underrun_flag(unr0), .flag_clr(flag_clr)
`endif
  );

  spi_slave_fifo #(.CPOL(1'b1), .CPHA(1'b1)) u_dut3 (
    .clk(clk), .reset(reset),
    .sclk_in(sclk), .mosi_in(mosi), .ss_n_in(ss_n3),
    .miso_out(miso3),
    .rx_data(rx_data3), .rx_valid(rx_valid3), .rx_ready(rx_ready3),
    .tx_data(tx_data3), .tx_valid(tx_valid3), .tx_ready(tx_ready3)
`ifdef SPI_SLAVE_FIFO_STATUS_EN
    , .overrun_flag(ovr3), .underrun_flag(unr3), .flag_clr(flag_clr)
`endif
  );

  spi_slave_fifo #(
    .DATA_W(12), .FIFO_DEPTH(2), .CPOL(1'b0), .CPHA(1'b1)
  ) u_dut1 (
    .clk(clk), .reset(reset),
    .sclk_in(sclk), .mosi_in(mosi), .ss_n_in(ss_n1),
    .miso_out(miso1),
    .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(rx_ready1),
    .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1)
`ifdef SPI_SLAVE_FIFO_STATUS_EN
    , .overrun_flag(ovr1), .underrun_flag(unr1), .flag_clr(flag_clr)
`endif
  );

  always @(posedge clk) begin
    if (tx_ready0) txr_cnt0 <= txr_cnt0 + 1;
    if (rx_valid1 && rx_ready1) begin
      pop_cnt1  <= pop_cnt1 + 1;
      last_pop1 <= rx_data1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  function automatic logic miso_sel(input int sel);
    case (sel)
      0:       return miso0;
      1:       return miso1;
      default: return miso3;
    endcase
  endfunction

  function automatic logic [31:0] rx_data_sel(input int sel);
    case (sel)
      0:       return 32'(rx_data0);
      1:       return 32'(rx_data1);
      default: return 32'(rx_data3);
    endcase
  endfunction

  task automatic set_ready(input int sel, input logic v);
    case (sel)
      0:       rx_ready0 = v;
      1:       rx_ready1 = v;
      default: rx_ready3 = v;
    endcase
  endtask

  task automatic pop_chk(input int sel, input string tag,
                         input logic [31:0] exp);
    chk(tag, rx_data_sel(sel), exp);
    set_ready(sel, 1'b1);
    tick(1);
    set_ready(sel, 1'b0);
  endtask

  // One word, MSB first; returns what the master sampled on MISO.
  task automatic xfer(input int sel, input bit cpol, input bit cpha,
                      input int nbits, input logic [31:0] mo,
                      output logic [31:0] mi_o);
    mi_o = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      if (!cpha) begin
        mosi = mo[i];
        tick(H);
        mi_o = {mi_o[30:0], miso_sel(sel)};
        sclk = ~cpol;
        tick(H);
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = mo[i];
        tick(H);
        mi_o = {mi_o[30:0], miso_sel(sel)};
        sclk = cpol;
        tick(H);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    sclk = 1'b0; mosi = 1'b0;
    ss_n0 = 1'b1; ss_n3 = 1'b1; ss_n1 = 1'b1;
    rx_ready0 = 1'b0; rx_ready3 = 1'b0; rx_ready1 = 1'b0;
    tx_data0 = '0; tx_data3 = '0; tx_data1 = '0;
    tx_valid0 = 1'b0; tx_valid3 = 1'b0; tx_valid1 = 1'b0;
`ifdef SPI_SLAVE_FIFO_STATUS_EN
    flag_clr = 1'b0;
`endif
    tick(3);
    chk("rst_rx_valid", 32'(rx_valid0), 32'h0);
    chk("rst_rx_data", 32'(rx_data0), 32'h0);
    chk("rst_tx_ready", 32'(tx_ready0), 32'h0);
    chk("rst_miso", 32'(miso0), 32'h0);
    reset = 1'b0;
    tick(4);

    // Mode 0: receive 0xA5, send 0x3C
    tx_data0 = 8'h3C; tx_valid0 = 1'b1;
    ss_n0 = 1'b0;
    tick(6);
    xfer(0, 1'b0, 1'b0, 8, 32'hA5, mi);
    tick(4);
    chk("m0_rx_valid", 32'(rx_valid0), 32'h1);
    chk("m0_rx_data", 32'(rx_data0), 32'hA5);
    chk("m0_miso", mi, 32'h3C);
    ss_n0 = 1'b1;
    tick(6);
    chk("m0_tx_ready_cnt", 32'(txr_cnt0), 32'd2);
    pop_chk(0, "m0_pop", 32'hA5);
    chk("m0_empty", 32'(rx_valid0), 32'h0);

    // Underrun: two words with no TX data
    tx_valid0 = 1'b0;
`ifdef SPI_SLAVE_FIFO_STATUS_EN
    chk("unr_before", 32'(unr0), 32'h0);
`endif
    ss_n0 = 1'b0;
    tick(6);
    xfer(0, 1'b0, 1'b0, 8, 32'h11, mi);
    chk("unr_miso_w0", mi, 32'h00);
    xfer(0, 1'b0, 1'b0, 8, 32'h22, mi);
    chk("unr_miso_w1", mi, 32'h00);
    tick(4);
    ss_n0 = 1'b1;
    tick(6);
    chk("unr_tx_ready_cnt", 32'(txr_cnt0), 32'd2);
`ifdef SPI_SLAVE_FIFO_STATUS_EN
    chk("unr_flag_set", 32'(unr0), 32'h1);
    flag_clr = 1'b1;
    tick(1);
    flag_clr = 1'b0;
    chk("unr_flag_clr", 32'(unr0), 32'h0);
`endif
    pop_chk(0, "unr_pop0", 32'h11);
    pop_chk(0, "unr_pop1", 32'h22);
    chk("unr_empty", 32'(rx_valid0), 32'h0);

    // Aborted 3-bit word, then 0x7E
    tx_data0 = 8'hF0; tx_valid0 = 1'b1;
    ss_n0 = 1'b0;
    tick(6);
    xfer(0, 1'b0, 1'b0, 3, 32'h5, mi);
    tick(2);
    ss_n0 = 1'b1;
    tick(8);
    chk("abort_nothing", 32'(rx_valid0), 32'h0);
    ss_n0 = 1'b0;
    tick(6);
    xfer(0, 1'b0, 1'b0, 8, 32'h7E, mi);
    chk("abort_miso", mi, 32'hF0);
    tick(4);
    ss_n0 = 1'b1;
    tick(6);
    chk("idle_miso", 32'(miso0), 32'h0);
    pop_chk(0, "abort_pop", 32'h7E);
    chk("abort_empty", 32'(rx_valid0), 32'h0);

    // Reset mid-word with two entries queued
    tx_data0 = 8'hFF;
    ss_n0 = 1'b0;
    tick(6);
    xfer(0, 1'b0, 1'b0, 8, 32'h12, mi);
    xfer(0, 1'b0, 1'b0, 8, 32'h34, mi);
    tick(4);
    ss_n0 = 1'b1;
    tick(6);
    chk("rstmid_rx_data", 32'(rx_data0), 32'h12);
    ss_n0 = 1'b0;
    tick(6);
    xfer(0, 1'b0, 1'b0, 3, 32'h5, mi);
    tick(1);
    chk("rstmid_miso_pre", 32'(miso0), 32'h1);
    reset = 1'b1;
    tick(1);
    chk("rstmid_rx_valid", 32'(rx_valid0), 32'h0);
    chk("rstmid_miso", 32'(miso0), 32'h0);
    ss_n0 = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(6);
    ss_n0 = 1'b0;
    tick(6);
    xfer(0, 1'b0, 1'b0, 8, 32'h81, mi);
    tick(4);
    ss_n0 = 1'b1;
    tick(6);
    chk("rstmid_valid_81", 32'(rx_valid0), 32'h1);
    pop_chk(0, "rstmid_pop", 32'h81);
    chk("rstmid_empty", 32'(rx_valid0), 32'h0);

    // Mode 3: five words into a 4-deep FIFO
    tx_data3 = 8'h96; tx_valid3 = 1'b1;
    sclk = 1'b1;
    tick(6);
    ss_n3 = 1'b0;
    tick(6);
    for (int w = 1; w <= 5; w++) begin
      xfer(3, 1'b1, 1'b1, 8, 32'(w), mi);
      if (w == 1) chk("m3_miso", mi, 32'h96);
`ifdef SPI_SLAVE_FIFO_STATUS_EN
      if (w == 4) begin
        tick(2);
        chk("m3_no_ovr_yet", 32'(ovr3), 32'h0);
      end
`endif
    end
    tick(4);
    ss_n3 = 1'b1;
    tick(6);
`ifdef SPI_SLAVE_FIFO_STATUS_EN
    chk("m3_ovr_flag", 32'(ovr3), 32'h1);
`endif
    pop_chk(3, "m3_pop1", 32'h01);
    pop_chk(3, "m3_pop2", 32'h02);
    pop_chk(3, "m3_pop3", 32'h03);
    pop_chk(3, "m3_pop4", 32'h04);
    chk("m3_empty", 32'(rx_valid3), 32'h0);

    // Mode 1, 12 bits: streaming consumer, then push+pop at full
    sclk = 1'b0;
    tick(6);
    tx_data1 = 12'h5A3; tx_valid1 = 1'b1;
    rx_ready1 = 1'b1;
    ss_n1 = 1'b0;
    tick(6);
    xfer(1, 1'b0, 1'b1, 12, 32'hABC, mi);
    tick(6);
    ss_n1 = 1'b1;
    tick(4);
    chk("m1_miso", mi, 32'h5A3);
    chk("m1_pop_cnt", 32'(pop_cnt1), 32'd1);
    chk("m1_pop_word", 32'(last_pop1), 32'hABC);
    chk("m1_empty", 32'(rx_valid1), 32'h0);
    rx_ready1 = 1'b0;
    ss_n1 = 1'b0;
    tick(6);
    xfer(1, 1'b0, 1'b1, 12, 32'h111, mi);
    xfer(1, 1'b0, 1'b1, 12, 32'h222, mi);
    xfer(1, 1'b0, 1'b1, 11, 32'h199, mi);
    sclk = 1'b1;
    mosi = 1'b1;
    tick(H);
    sclk = 1'b0;
    tick(3);
    rx_ready1 = 1'b1;
    tick(1);
    rx_ready1 = 1'b0;
    tick(4);
    ss_n1 = 1'b1;
    tick(4);
    chk("m1_full_pop_cnt", 32'(pop_cnt1), 32'd2);
    chk("m1_full_popped", 32'(last_pop1), 32'h111);
`ifdef SPI_SLAVE_FIFO_STATUS_EN
    chk("m1_no_ovr", 32'(ovr1), 32'h0);
`endif
    pop_chk(1, "m1_head_222", 32'h222);
    pop_chk(1, "m1_head_333", 32'h333);
    chk("m1_drained", 32'(rx_valid1), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_fifo.md
SPI_SLAVE_FIFO -- requirements
Module: spi_slave_fifo

Interface
REQ-001 Parameter DATA_W, default 8: SPI word width in bits, legal range 4..32.
REQ-002 Parameter FIFO_DEPTH, default 4: RX FIFO entries; power of two, 2..64.
REQ-003 Parameter CPOL, default 0: SCLK idle level.
REQ-004 Parameter CPHA, default 0: 0 samples on the leading edge, 1 samples on the trailing edge.
REQ-005 clk  in  1  system clock; the only clock; must be at least 4x the SCLK frequency.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 sclk_in  in  1  SPI clock, asynchronous to clk.
REQ-008 mosi_in  in  1  master-out data, asynchronous to clk.
REQ-009 ss_n_in  in  1  active-low slave select, asynchronous to clk.
REQ-010 miso_out  out  1  slave-out data.
REQ-011 rx_data  out  DATA_W  head word of the RX FIFO.
REQ-012 rx_valid  out  1  RX FIFO non-empty.
REQ-013 rx_ready  in  1  consumer pops the head word when rx_valid=1.
REQ-014 tx_data  in  DATA_W  next word to transmit.
REQ-015 tx_valid  in  1  tx_data is available.
REQ-016 tx_ready  out  1  one-cycle pulse; tx_data is accepted in this cycle.

Function
REQ-017 sclk_in, mosi_in and ss_n_in SHALL each pass through a 2-flop synchronizer; SCLK edges and ss_n edges SHALL be detected from the synchronized values.
REQ-018 FSM states: IDLE (ss_n high) and SHIFT (ss_n low); IDLE->SHIFT on the synchronized ss_n fall; any state->IDLE on the synchronized ss_n rise.
REQ-019 Bits SHALL be shifted MSB first; a bit counter of width $clog2(DATA_W) SHALL wrap to 0 after DATA_W sampling edges, and framing SHALL continue for back-to-back words within one frame.
REQ-020 The completed RX word SHALL be written into the FIFO in the clk cycle after the final sampling edge is detected; if the FIFO was empty, rx_valid SHALL rise one cycle later.
REQ-021 RX FIFO full at the push: the word SHALL be dropped and the overrun condition raised; FIFO contents SHALL be unchanged.
REQ-022 Push and pop in the same cycle on a full FIFO: the pop SHALL be served first and the push SHALL succeed; on an empty FIFO, the pop SHALL be ignored.
REQ-023 TX load SHALL occur on the ss_n fall and at every word wrap: if tx_valid=1, tx_data is loaded and tx_ready pulses; otherwise all zeros are loaded and the underrun condition is raised.
REQ-024 CPHA=0: the MSB SHALL be on miso_out within 3 clk of the ss_n fall, and subsequent bits SHALL change on trailing edges.
REQ-025 CPHA=1: miso_out SHALL change on leading edges and the SHALL sample on trailing edges.
REQ-026 In IDLE, miso_out SHALL be 0.
REQ-027 An ss_n rise mid-word SHALL discard the partial RX bits and reset the bit counter; FIFO contents SHALL be unaffected.

Reset
REQ-028 Reset SHALL clear the FIFO pointers and the count, with rx_valid=0, rx_data=0, tx_ready=0, miso_out=0.
REQ-029 Reset SHALL set the FSM to IDLE, and clear the bit counter, the shift registers and the synchronizers (ss_n synchronizer stages to 1, SCLK stages to CPOL).
REQ-030 Reset asserted mid-frame SHALL abort the frame; after reset release, the block SHALL wait for a fresh ss_n fall before shifting.

Configuration
REQ-031 Macro SPI_SLAVE_FIFO_STATUS_EN defined: the block SHALL add output ports overrun_flag (1), underrun_flag (1) and input port flag_clr (1). The flags are sticky, set per REQ-021/REQ-023, and cleared by flag_clr; set SHALL win over clear in the same cycle.
REQ-032 Macro undefined: those ports and their registers SHALL be absent; overrun words are still dropped and underrun still sends zeros.

Structure
REQ-033 Package spi_slave_pkg SHALL hold the FSM state enum (IDLE, SHIFT) and the SYNC_STAGES=2 constant.
REQ-034 The FIFO SHALL be a sub-module spi_rx_fifo (parameters DATA_W, FIFO_DEPTH; push/pop/full/empty interface); all other logic SHALL be in spi_slave_fifo.

Verification
REQ-035 Mode 0, DATA_W=8, master sends 0xA5 -> rx_data=0xA5 with rx_valid asserted within 4 clk of the last SCLK edge; miso_out carries the tx_data 0x3C preloaded with tx_valid=1.
REQ-036 Mode 3, one frame of 5 words 0x01..0x05, rx_ready held 0, FIFO_DEPTH=4 -> FIFO holds 0x01..0x04; 0x05 is dropped and overrun_flag=1.
REQ-037 tx_valid=0 throughout a 2-word frame -> MISO reads 0x00,0x00; tx_ready never pulses; underrun_flag=1; flag_clr clears it next cycle.
REQ-038 ss_n deasserted after 3 bits, then a full frame with 0x7E -> only 0x7E is in the FIFO.
REQ-039 reset pulsed mid-word with 2 FIFO entries -> rx_valid=0 and miso_out=0 next cycle; the next frame with 0x81 is received correctly.
REQ-040 DATA_W=12, FIFO_DEPTH=2, mode 1: master sends 0xABC while the consumer pops each cycle -> rx_data=0xABC; simultaneous push/pop at full loses no word.
